// File: rtl/dmem_if.sv
// Load/store request/response bus between the load-store unit (master) and
// the data-memory responder (slave).
interface dmem_if #(
    parameter int unsigned ADDR_WIDTH = 39,
    parameter int unsigned DATA_WIDTH = 64
);
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    req_we;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_wstrb;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-strobed word array with fixed-latency in-order responses.
// Optional DMEM_RESPONDER_STALL_EN adds LFSR-driven pseudo-random request back-pressure.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 39,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MEM_WORDS  = 4096,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    dmem_if.slave    bus
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = ADDR_WIDTH - 3;
    localparam int unsigned MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [CNT_W-1:0]  outstanding;
    logic              ready_c;
    logic              accept;
    logic              pop;
    logic              push;
    logic              rsp_valid_c;
    logic [IDX_W-1:0]  word_idx;
    logic [MEM_AW-1:0] mem_idx;
    logic              addr_err;
    rsp_t              new_rsp;

    logic [LATENCY-1:0] pipe_vld;
    rsp_t               pipe_rsp [LATENCY];

    rsp_t              q_mem [RSP_DEPTH];
    logic [PTR_W-1:0]  q_wr;
    logic [PTR_W-1:0]  q_rd;
    logic [CNT_W-1:0]  q_cnt;

    // Address decode and read of the pre-edge array value
    always_comb begin
        word_idx      = bus.req_addr[ADDR_WIDTH-1:3];
        mem_idx       = word_idx[MEM_AW-1:0];
        addr_err      = (bus.req_addr[2:0] != 3'b000) || (word_idx >= IDX_W'(MEM_WORDS));
        new_rsp.err   = addr_err;
        new_rsp.rdata = (bus.req_we || addr_err) ? '0 : mem[mem_idx];
    end

`ifdef DMEM_RESPONDER_STALL_EN
    logic [15:0] lfsr;

    // x^16 + x^14 + x^13 + x^11 + 1, shifting left
    always_ff @(posedge clk) begin
        if (!rst_n) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign ready_c = (outstanding < CNT_W'(RSP_DEPTH)) && (lfsr[1:0] != 2'b00);
`else
    assign ready_c = (outstanding < CNT_W'(RSP_DEPTH));
`endif

    assign accept      = bus.req_valid && ready_c;
    assign rsp_valid_c = (q_cnt != '0);
    assign pop         = rsp_valid_c && bus.rsp_ready;
    assign push        = pipe_vld[LATENCY-1];

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_rdata = rsp_valid_c ? q_mem[q_rd].rdata : '0;
    assign bus.rsp_err   = rsp_valid_c ? q_mem[q_rd].err : 1'b0;

    // Byte-strobed store commit at the accepting edge; array is never reset
    always_ff @(posedge clk) begin
        if (rst_n && accept && bus.req_we && !addr_err) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (bus.req_wstrb[i]) mem[mem_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
            end
        end
    end

    // Credit counter covering delay line plus response queue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= accept;
            for (int i = 1; i < LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe_rsp[0] <= new_rsp;
        for (int i = 1; i < LATENCY; i++) pipe_rsp[i] <= pipe_rsp[i-1];
    end

    // Response queue; credits guarantee push never finds it full
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
        end else begin
            if (push) q_wr <= (q_wr == PTR_W'(RSP_DEPTH - 1)) ? '0 : q_wr + PTR_W'(1);
            if (pop)  q_rd <= (q_rd == PTR_W'(RSP_DEPTH - 1)) ? '0 : q_rd + PTR_W'(1);
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + CNT_W'(1);
                2'b01:   q_cnt <= q_cnt - CNT_W'(1);
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) q_mem[q_wr] <= pipe_rsp[LATENCY-1];
    end
endmodule
